// File: rtl/std_mult_seq.sv
// Iterative shift-and-add multiplier with a go/done handshake.
// Produces the full 2*WIDTH product one partial-product step per cycle, with optional signed mode.
module std_mult_seq #(
   parameter int WIDTH  = 32,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_hi,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for go; done cycle also sits here
   // RUN   | one partial-product add/shift per edge
   // FIN   | register (sign-corrected) product, pulse done
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [WIDTH-1:0]   out_q, out_d;
   logic [WIDTH-1:0]   out_hi_q, out_hi_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   l_mag, r_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] prod;

   // Magnitudes are taken as unsigned, so the most negative value maps to 2^(WIDTH-1).
   always_comb begin
      l_mag = left;
      r_mag = right;
      if (SIGNED != 0 && left[WIDTH-1])  l_mag = -left;
      if (SIGNED != 0 && right[WIDTH-1]) r_mag = -right;
   end

   assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
   assign prod = neg_q ? -acc_q : acc_q;

   // Low half of acc holds the multiplier and shifts out as product bits shift in.
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      out_d    = out_q;
      out_hi_d = out_hi_q;
      done_d   = 1'b0;
      if (!go) begin
         state_d  = IDLE;
         out_d    = '0;
         out_hi_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               mcand_d  = l_mag;
               acc_d    = {{WIDTH{1'b0}}, r_mag};
               neg_d    = (SIGNED != 0) ? (left[WIDTH-1] ^ right[WIDTH-1]) : 1'b0;
               cnt_d    = CW'(WIDTH);
               out_d    = '0;
               out_hi_d = '0;
               if (left == '0 || right == '0) begin
                  acc_d   = '0;
                  state_d = FIN;
               end else begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
               else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = FIN;
            end
            FIN: begin
               out_d    = prod[WIDTH-1:0];
               out_hi_d = prod[2*WIDTH-1:WIDTH];
               done_d   = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         out_q    <= '0;
         out_hi_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
         done_q   <= done_d;
      end
   end

   assign out    = out_q;
   assign out_hi = out_hi_q;
   assign done   = done_q;

   // Simulation-only cross-check of the registered product against a native multiply.
   logic [WIDTH-1:0]   chk_l_q, chk_r_q;
   logic [2*WIDTH-1:0] chk_le, chk_re, chk_p;

   always_ff @(posedge clk) begin
      if (reset && go && state_q == IDLE) begin
         chk_l_q <= left;
         chk_r_q <= right;
      end
   end

   always_comb begin
      chk_le = {{WIDTH{1'b0}}, chk_l_q};
      chk_re = {{WIDTH{1'b0}}, chk_r_q};
      if (SIGNED != 0) begin
         chk_le = {{WIDTH{chk_l_q[WIDTH-1]}}, chk_l_q};
         chk_re = {{WIDTH{chk_r_q[WIDTH-1]}}, chk_r_q};
      end
      chk_p = chk_le * chk_re;
   end

   always_ff @(posedge clk) begin
      if (reset && done_q && {out_hi_q, out_q} != chk_p)
         $error("std_mult_seq product %h expected %h", {out_hi_q, out_q}, chk_p);
   end

endmodule

// File: tb/tb_std_mult_seq.sv
// Scoreboard bench for std_mult_seq: unsigned and signed 8-bit instances, directed vectors.
module tb_std_mult_seq;

   typedef struct {
      logic [15:0] prod;
      int          due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       go_u, go_s;
   logic [7:0] l_u, r_u, l_s, r_s;
   logic [7:0] out_u, hi_u, out_s, hi_s;
   logic       done_u, done_s;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb_u[$];
   exp_t sb_s[$];

   std_mult_seq #(.WIDTH(8), .SIGNED(0)) u_dut (
      .clk(clk), .reset(rst_n), .go(go_u), .left(l_u), .right(r_u),
      .out(out_u), .out_hi(hi_u), .done(done_u)
   );

   std_mult_seq #(.WIDTH(8), .SIGNED(1)) s_dut (
      .clk(clk), .reset(rst_n), .go(go_s), .left(l_s), .right(r_s),
      .out(out_s), .out_hi(hi_s), .done(done_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop an expected entry whenever done is presented.
   exp_t mu, ms;
   always @(negedge clk) begin
      if (done_u) begin
         if (sb_u.size() == 0) chk("u_unexpected_done", 32'd1, 32'd0);
         else begin
            mu = sb_u.pop_front();
            chk("u_product", {16'd0, hi_u, out_u}, {16'd0, mu.prod});
            chk("u_done_cycle", cyc, mu.due);
         end
      end
      if (done_s) begin
         if (sb_s.size() == 0) chk("s_unexpected_done", 32'd1, 32'd0);
         else begin
            ms = sb_s.pop_front();
            chk("s_product", {16'd0, hi_s, out_s}, {16'd0, ms.prod});
            chk("s_done_cycle", cyc, ms.due);
         end
      end
   end

   task automatic push(input bit sel, input logic [15:0] p, input int due);
      exp_t e;
      e.prod = p;
      e.due  = due;
      if (sel) sb_s.push_back(e);
      else     sb_u.push_back(e);
   endtask

   task automatic wait_done(input bit sel);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel ? done_s : done_u) && n < 40);
      if (!(sel ? done_s : done_u)) chk(sel ? "s_done_timeout" : "u_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic run(input bit sel, input logic [7:0] l, input logic [7:0] r,
                      input logic [15:0] p, input int lat);
      @(negedge clk);
      if (sel) begin l_s = l; r_s = r; go_s = 1'b1; end
      else     begin l_u = l; r_u = r; go_u = 1'b1; end
      push(sel, p, cyc + 1 + lat);
      wait_done(sel);
      if (sel) go_s = 1'b0;
      else     go_u = 1'b0;
      @(negedge clk);
      if (sel) chk("s_clear_on_go_low", {15'd0, done_s, hi_s, out_s}, 32'd0);
      else     chk("u_clear_on_go_low", {15'd0, done_u, hi_u, out_u}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      go_u = 1'b0; go_s = 1'b0;
      l_u = 8'd0; r_u = 8'd0; l_s = 8'd0; r_s = 8'd0;
      repeat (3) @(negedge clk);
      chk("u_reset_state", {15'd0, done_u, hi_u, out_u}, 32'd0);
      chk("s_reset_state", {15'd0, done_s, hi_s, out_s}, 32'd0);
      rst_n = 1'b1;

      run(0, 8'd13, 8'd11, 16'h008F, 9);
      run(0, 8'd255, 8'd255, 16'hFE01, 9);
      run(0, 8'd0, 8'd200, 16'h0000, 1);
      run(0, 8'd200, 8'd0, 16'h0000, 1);

      // Abort after four RUN edges: no done, outputs stay zero.
      @(negedge clk);
      l_u = 8'd100; r_u = 8'd3; go_u = 1'b1;
      repeat (5) @(negedge clk);
      go_u = 1'b0;
      @(negedge clk);
      chk("u_abort_outputs", {15'd0, done_u, hi_u, out_u}, 32'd0);
      repeat (12) @(negedge clk);
      run(0, 8'd7, 8'd9, 16'd63, 9);

      // Reset at the 5th RUN edge with go held, then restart from IDLE.
      @(negedge clk);
      l_u = 8'd100; r_u = 8'd3; go_u = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("u_reset_mid_op", {15'd0, done_u, hi_u, out_u}, 32'd0);
      push(0, 16'd300, cyc + 1 + 9);
      rst_n = 1'b1;
      wait_done(0);
      go_u = 1'b0;
      @(negedge clk);

      // Back-to-back with go held; mid-run operand changes must be ignored.
      @(negedge clk);
      l_u = 8'd2; r_u = 8'd3; go_u = 1'b1;
      push(0, 16'd6, cyc + 1 + 9);
      push(0, 16'd20, cyc + 1 + 19);
      repeat (3) @(negedge clk);
      l_u = 8'd4; r_u = 8'd5;
      wait_done(0);
      repeat (3) @(negedge clk);
      l_u = 8'd9; r_u = 8'd9;
      wait_done(0);
      go_u = 1'b0;
      @(negedge clk);

      run(1, 8'hFD, 8'd5, 16'hFFF1, 9);
      run(1, 8'h80, 8'h80, 16'h4000, 9);
      run(1, 8'h80, 8'h01, 16'hFF80, 9);
      run(1, 8'hF9, 8'hF7, 16'h003F, 9);
      run(1, 8'h00, 8'hFB, 16'h0000, 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb_u.size() + sb_s.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/std_mult_seq.md
# std_mult_seq

Iterative shift-and-add multiplier producing the full double-width product of two WIDTH-bit operands: one partial-product step per cycle, under the standard go/done handshake. It is the multiplicative counterpart of the sequential divider. Schedulers use it where a pipelined DSP multiply is unavailable or where the high half of the product is needed. An optional signed mode wraps the unsigned datapath with magnitude/sign correction.

## Interface
- WIDTH, 32, operand width in bits; supported range 2..64
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- go  input  1  start/hold request; must stay high until done is seen
- left  input  WIDTH  multiplicand; sampled only on the start edge
- right  input  WIDTH  multiplier; sampled only on the start edge
- out  output  WIDTH  low WIDTH bits of the product
- out_hi  output  WIDTH  high WIDTH bits of the product
- done  output  1  single-cycle completion pulse

## Operation
- States: IDLE, RUN, FIN.
- Reset (reset low at an edge) forces state IDLE, out=0, out_hi=0, done=0, and internal accumulator and counter to 0. Reset overrides go.
- IDLE:
  - When go=1, latch operands. In signed mode, latch magnitudes: negate if the MSB is set, treated as unsigned (so -2^(WIDTH-1) becomes 2^(WIDTH-1)). Record neg = left[MSB] XOR right[MSB]; neg is forced to 0 in unsigned mode.
  - Clear the 2*WIDTH accumulator, load count=WIDTH, go to RUN.
  - Zero shortcut: if left==0 or right==0 on the start edge, go directly to FIN with result 0.
- RUN, each edge:
  - If multiplier LSB=1, add the multiplicand into the upper WIDTH+1 bits of the accumulator.
  - Shift the {carry, acc, multiplier} chain right by 1.
  - Decrement count. On the edge where count reaches 0, go to FIN.
- FIN, one edge:
  - Register the product into {out_hi, out}, negated modulo 2^(2*WIDTH) if neg=1.
  - Assert done=1 for the following cycle. Return to IDLE.
- done is high exactly one cycle. out/out_hi hold their value until the next start edge, go dropping, or reset.
- go low at any edge in any state: abort to IDLE, done=0, out=0, out_hi=0. No partial result is ever output.
- go still high in IDLE after the done cycle starts a new operation from the current left/right. Controllers drop go the cycle done is seen.
- Width rules: the accumulator adder is WIDTH+1 bits, so the carry is retained. Full product is exact for all operands; no overflow or saturation.

## Timing
- Edge E0: go sampled high in IDLE (start edge).
- Normal operation: RUN occupies E1..E_WIDTH; FIN at E_(WIDTH+1). done is high in the cycle after E_(WIDTH+1), which is WIDTH+1 cycles after the start edge. Results are valid in that same cycle.
- Zero shortcut: FIN at E1; done high in the cycle after E1.
- Throughput: one operation per WIDTH+2 cycles with go held continuously. The IDLE re-entry cycle is the restart edge.
- Operand changes after E0 have no effect on the current operation.
- reset low and go low on the same edge: reset behaviour applies; it has the same visible effect.
- The self-check under VERILATOR compares {out_hi,out} against left*right at 2*WIDTH bits, signed per SIGNED, in the done cycle. A mismatch raises $error.

## Test plan
- WIDTH=8, SIGNED=0, left=13, right=11 -> out=0x8F, out_hi=0x00; done rises exactly 9 cycles after the start edge and lasts 1 cycle.
- WIDTH=8, SIGNED=0, 255*255 -> out=0x01, out_hi=0xFE. Then left=0, right=200 -> done 1 cycle after start, out=0, out_hi=0.
- WIDTH=8, SIGNED=1: -3*5 -> out=0xF1, out_hi=0xFF; -128*-128 -> out=0x00, out_hi=0x40; -128*1 -> out=0x80, out_hi=0xFF.
- Abort: start 100*3, drop go after 4 RUN cycles -> done never asserts and out=out_hi=0. Re-raise go with 7*9 -> out=63 after 9 cycles.
- Reset mid-op: pull reset low at the 5th RUN edge with go high -> next cycle shows IDLE and all outputs 0. Release reset with go held -> a new operation starts and completes correctly.
- Back-to-back: hold go high through done with new operands 2*3 then 4*5 -> two done pulses 10 cycles apart with outputs 6 then 20; operand changes mid-run are ignored.
